// File: rtl/pipe_cba_pkg.sv
// Shared helpers for the pipelined carry-bypass adder: block-count
// derivation and the parameter legality rule used at elaboration.
package pipe_cba_pkg;

  // Number of carry-bypass blocks, which is also the number of pipeline stages.
  function automatic int cba_nblk(input int width, input int blk);
    return width / blk;
  endfunction

  // Legal only when the width splits evenly into blocks of at least two bits.
  function automatic bit cba_params_ok(input int width, input int blk);
    return (blk >= 2) && (width >= blk) && ((width % blk) == 0);
  endfunction

endpackage

// File: rtl/pipe_cba_adder_block.sv
// One carry-bypass block: BLK-bit ripple adder whose carry-out is taken
// straight from c_in whenever every bit propagates.
module cba_block #(
  parameter int BLK = 8
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           c_in,
  output logic [BLK-1:0] s,
  output logic           c_out,
  output logic           c_msb
);
  logic [BLK-1:0] p;
  logic [BLK:0]   c;

  assign p = a ^ b;

  // Ripple the carry through the block and form each sum bit.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = c_in;
    for (int i = 0; i < BLK; i++) begin
      s[i]   = p[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (p[i] & c[i]);
    end
  end

  // Carry into the top bit feeds the signed-overflow detector downstream.
  assign c_msb = c[BLK-1];
  // Bypass mux: an all-propagate block passes its incoming carry unchanged.
  assign c_out = (&p) ? c_in : c[BLK];

endmodule

// File: rtl/pipe_cba_adder.sv
// Pipelined carry-bypass adder/subtractor. Each stage resolves one block
// of BLK bits, carrying the partial sum, the block carry and the not-yet
// processed operand bits forward. Stages advance with a combinational
// ready chain so bubbles collapse and a full pipe still streams.
module pipe_cba_adder
  import pipe_cba_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLK   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NBLK = cba_nblk(WIDTH, BLK);

  if (!cba_params_ok(WIDTH, BLK)) begin : g_param_check
    $error("pipe_cba_adder: WIDTH must be a positive multiple of BLK and BLK must be >= 2");
  end

  // Handshake: a transfer happens on a cycle where valid and ready are both
  // high at the rising edge; valid never waits on ready, and ready is a pure
  // combinational function of stage occupancy and out_ready.

  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic [NBLK-1:0]  v;
  logic [NBLK-1:0]  adv;

  // Subtraction is A + ~B + 1, so the external carry-in is ignored there.
  assign b_eff = op_sub ? ~b : b;
  assign c0    = op_sub | cin;

  // A stage may load when it is empty or when everything after it can move.
  always_comb begin
    logic run;
    run = out_ready;
    adv = '0;
    for (int k = NBLK - 1; k >= 0; k--) begin
      run    = run | ~v[k];
      adv[k] = run;
    end
  end

  for (genvar k = 0; k < NBLK; k++) begin : g_stage
    localparam int UPW = WIDTH - BLK * k;

    logic                 up_v;
    logic [UPW-1:0]       up_a;
    logic [UPW-1:0]       up_b;
    logic                 up_c;
    logic [BLK*(k+1)-1:0] nxt_s;
    logic [BLK-1:0]       blk_s;
    logic                 blk_cout;
    logic                 blk_cmsb;
    logic                 v_q;
    logic [BLK*(k+1)-1:0] s_q;
    logic                 c_q;

    if (k == 0) begin : g_src
      assign up_v  = in_valid;
      assign up_a  = a;
      assign up_b  = b_eff;
      assign up_c  = c0;
      assign nxt_s = blk_s;
    end else begin : g_src
      assign up_v  = g_stage[k-1].v_q;
      assign up_a  = g_stage[k-1].g_ops.a_q;
      assign up_b  = g_stage[k-1].g_ops.b_q;
      assign up_c  = g_stage[k-1].c_q;
      assign nxt_s = {blk_s, g_stage[k-1].s_q};
    end

    cba_block #(.BLK(BLK)) u_blk (
      .a     (up_a[BLK-1:0]),
      .b     (up_b[BLK-1:0]),
      .c_in  (up_c),
      .s     (blk_s),
      .c_out (blk_cout),
      .c_msb (blk_cmsb)
    );

    // Capture this block's result together with the bits resolved so far.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        s_q <= '0;
        c_q <= 1'b0;
      end else if (adv[k]) begin
        v_q <= up_v;
        s_q <= nxt_s;
        c_q <= blk_cout;
      end
    end

    assign v[k] = v_q;

    if (k < NBLK - 1) begin : g_ops
      logic [UPW-BLK-1:0] a_q;
      logic [UPW-BLK-1:0] b_q;
      logic               unused_cmsb;

      assign unused_cmsb = blk_cmsb;

      // Carry the operand bits of the remaining blocks down the pipe.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv[k]) begin
          a_q <= up_a[UPW-1:BLK];
          b_q <= up_b[UPW-1:BLK];
        end
      end
    end else begin : g_last
      logic cmsb_q;

      // Keep the carry into the sign bit for overflow detection.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cmsb_q <= 1'b0;
        end else if (adv[k]) begin
          cmsb_q <= blk_cmsb;
        end
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v[NBLK-1];
  assign sum       = g_stage[NBLK-1].s_q;
  assign cout      = g_stage[NBLK-1].c_q;
  assign ovf       = g_stage[NBLK-1].g_last.cmsb_q ^ g_stage[NBLK-1].c_q;

endmodule

// File: tb/tb_pipe_cba_adder.sv
// Self-checking bench for pipe_cba_adder (WIDTH=16, BLK=4): directed
// vectors, backpressure, mid-flight reset and a long random stream, all
// scored in order against an arithmetic reference model.
module tb_pipe_cba_adder;
  localparam int W  = 16;
  localparam int BK = 4;
  localparam int NB = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         op_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  // Expected responses packed as {cout, ovf, sum}.
  logic [W+1:0] exp_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int fires = 0;
  int ready_pct = 100;

  pipe_cba_adder #(.WIDTH(W), .BLK(BK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: plain wide-integer arithmetic.
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic c, input logic s);
    int unsigned full;
    logic [W-1:0] r;
    logic co;
    logic ov;
    if (s) full = 32'(x) + 32'(16'hFFFF - y) + 32'd1;
    else   full = 32'(x) + 32'(y) + 32'(c);
    r  = full[W-1:0];
    co = full[W];
    if (s) ov = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    else   ov = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    return {co, ov, r};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  // Driver: offer one transaction for one cycle; record it if accepted.
  task automatic try_send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                          input logic to, input logic [W+1:0] e, output bit acc);
    @(negedge clk);
    a = ta; b = tb; cin = tc; op_sub = to; in_valid = 1'b1;
    #4;
    acc = in_ready;
    if (acc) begin
      exp_q.push_back(e);
      acc_cyc = cyc;
    end
    @(posedge clk);
  endtask

  // Driver: keep offering until accepted, with a bounded wait.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                      input logic to, input logic [W+1:0] e);
    bit acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 500) begin
      try_send(ta, tb, tc, to, e, acc);
      tries++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got=not accepted want=accepted within 500 cycles");
    end
  endtask

  task automatic drop();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    drop();
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard monitor: randomises out_ready and checks every output transfer.
  initial begin : monitor
    logic [W+1:0] e;
    forever begin
      @(negedge clk);
      out_ready = (int'($urandom_range(0, 99)) < ready_pct);
      #4;
      if (rst_n && out_valid && out_ready) begin
        fires++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_result: got={cout,ovf,sum}=%h want=no result", {cout, ovf, sum});
        end else begin
          e = exp_q.pop_front();
          check("result{cout,ovf,sum}", 32'({cout, ovf, sum}), 32'(e));
        end
      end
    end
  end

  // Stimulus sequence.
  initial begin : stim
    bit acc;
    int lat;
    int n_acc;
    int f0;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rc;
    logic ro;

    #2;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_outputs", 32'({cout, ovf, sum}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Full-bypass add and its latency.
    ready_pct = 100;
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0000});
    lat = -1;
    for (int i = 0; i < 12 && lat < 0; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #4;
      if (out_valid) lat = cyc - acc_cyc;
    end
    check("latency", 32'(lat), 32'(NB));
    drain("drain_first");

    // Directed arithmetic corners, back to back.
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000});
    send(16'h1234, 16'h0000, 1'b1, 1'b0, {1'b0, 1'b0, 16'h1235});
    send(16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    send(16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
    send(16'h0010, 16'h0003, 1'b1, 1'b1, {1'b1, 1'b0, 16'h000D});
    drain("drain_directed");

    // Backpressure: six offers with the output blocked.
    ready_pct = 0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      ro = 1'($urandom_range(0, 1));
      try_send(ra, rb, rc, ro, ref_model(ra, rb, rc, ro), acc);
      if (acc) n_acc++;
    end
    check("backpressure_accepts", 32'(n_acc), 32'(NB));
    #1;
    check("full_in_ready", 32'(in_ready), 32'd0);
    ready_pct = 100;
    f0 = fires;
    for (int i = 0; i < 2; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      try_send(ra, rb, 1'b0, 1'b0, ref_model(ra, rb, 1'b0, 1'b0), acc);
      check("accept_while_full", 32'(acc), 32'd1);
    end
    drop();
    repeat (2) @(posedge clk);
    check("drain_rate", 32'(fires - f0), 32'd4);
    drain("drain_backpressure");

    // Reset with three transactions in flight.
    ready_pct = 0;
    for (int i = 0; i < 3; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      send(ra, rb, 1'b0, 1'b0, ref_model(ra, rb, 1'b0, 1'b0));
    end
    drop();
    @(posedge clk);
    @(negedge clk);
    #1;
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("reset_mid_out_valid", 32'(out_valid), 32'd0);
    check("reset_mid_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready_pct = 100;
    for (int i = 0; i < 5; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      ro = 1'($urandom_range(0, 1));
      send(ra, rb, rc, ro, ref_model(ra, rb, rc, ro));
    end
    drain("drain_post_reset");

    // Random stream with random output stalls and input bubbles.
    ready_pct = 70;
    for (int i = 0; i < 10000; i++) begin
      ra = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      ro = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) rb = ro ? ra : ~ra;
      else                           rb = W'($urandom);
      if ($urandom_range(0, 9) == 0) drop();
      send(ra, rb, rc, ro, ref_model(ra, rb, rc, ro));
    end
    ready_pct = 100;
    drain("final_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
